p_i_cache_line_fetch: RTL and testbench
=======================================

Name: p_i_cache_line_fetch

Overview:
- Line-fill engine directly downstream of the pipelined I-cache control.
- Converts the I-cache's single-line pmem_read request into a 4-beat, 64-bit burst read on the physical memory port, assembles the 256-bit line, and returns it with a one-cycle pmem_resp.
- Holds a single-entry next-line prefetch buffer, so sequential instruction streams are served with 1-cycle latency instead of a full burst.

Parameters:
- PREFETCH_EN, 1: 1 enables next-line prefetch; 0 makes the block a pure demand-fill adaptor (pf_valid never sets).
- ADDR_WIDTH, 32: byte address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pmem_read  in  1  line request from I-cache; held high until pmem_resp.
- pmem_address  in  ADDR_WIDTH  request byte address; bits [4:0] ignored.
- pmem_rdata  out  256  returned line, registered; valid only while pmem_resp=1.
- pmem_resp  out  1  one-cycle completion pulse, registered.
- burst_read  out  1  burst request to memory; held high until the 4th beat.
- burst_address  out  ADDR_WIDTH  line-aligned burst address (bits [4:0]=0), stable while burst_read=1.
- burst_rdata  in  64  beat data.
- burst_resp  in  1  beat valid. Beats may be non-consecutive; count burst_resp pulses.

Behaviour:
- Reset (async, any state, mid-burst included): state=IDLE, burst_read=0, burst_address=0, pmem_resp=0, pmem_rdata=0, beat_cnt=0, pf_valid=0, pf_pending=0, pf_addr=0, line_buf=0, pf_buf=0.
- Line address = address[31:5]. Beat k (k=0..3) fills line bits [64k+63:64k] (little-endian beat order).

States:
- IDLE
  - pmem_read=1 and pf_valid=1 and line(pmem_address)==line(pf_addr): go to RESP_PF.
  - else if pmem_read=1: latch burst_address = {pmem_address[31:5],5'b0}, beat_cnt=0, go to FILL_D.
  - else if pf_pending=1: burst_address=pf_addr, beat_cnt=0, go to FILL_P.
  - Demand always beats prefetch launch in the same cycle.
- FILL_D
  - burst_read=1. Each burst_resp writes the beat to line_buf[beat_cnt] and increments beat_cnt.
  - On the 4th beat: go to RESP_D.
- RESP_D
  - pmem_resp=1, pmem_rdata=line_buf.
  - pf_addr = burst_address+32 (wraps modulo 2^ADDR_WIDTH; 0xFFFFFFE0 -> 0x00000000), pf_valid=0, pf_pending=PREFETCH_EN.
  - Go to IDLE.
- FILL_P
  - burst_read=1, beats go to pf_buf.
  - On the 4th beat: pf_valid=1, pf_pending=0, go to IDLE.
  - A prefetch burst is never aborted. A demand request arriving meanwhile waits and is evaluated in IDLE after completion, so a matching demand hits the just-filled buffer.
- RESP_PF
  - pmem_resp=1, pmem_rdata=pf_buf, pf_valid=0, pf_addr=pf_addr+32 (wrap as above), pf_pending=PREFETCH_EN.
  - Go to IDLE.

Latency:
- Prefetch hit: request seen in IDLE at cycle N gives pmem_resp at N+1.
- Demand miss: pmem_resp the cycle after the 4th burst_resp.
- Demand during an in-flight prefetch: prefetch completion + 1 cycle (hit) or + full burst (miss).

Other rules:
- The I-cache deasserts pmem_read the cycle after pmem_resp. IDLE in that cycle sees pmem_read=0 and must not reissue.
- burst_resp while not in FILL_D/FILL_P is ignored.
- A demand miss to an address not matching pf_addr discards the prefetch buffer: pf_valid is cleared at RESP_D.
- At most one burst is outstanding. burst_read drops combinationally with the state change after the 4th beat.

Test Plan:
- Reset, then pmem_read at 0x00001004 with 4 beats 0x11..,0x22..,0x33..,0x44.. (gaps of 0-2 cycles between beats) -> burst_address=0x00001000; pmem_resp one cycle after the 4th beat; pmem_rdata={0x44..,0x33..,0x22..,0x11..}; then a prefetch burst at 0x00001020 launches.
- After the prefetch completes, pmem_read at 0x00001030 -> pmem_resp at request cycle +1 with pf_buf data, no burst issued; next prefetch at 0x00001040 starts.
- pmem_read at 0x00001030 asserted mid-prefetch of 0x00001020 -> prefetch runs to 4 beats uninterrupted, then pmem_resp 1 cycle later with prefetched data.
- Demand at 0x00002000 while the buffer holds 0x00001020 -> full burst at 0x00002000; pf_valid cleared; new prefetch at 0x00002020.
- Demand at 0xFFFFFFE0 -> prefetch burst_address=0x00000000 (wrap); with PREFETCH_EN=0, no burst follows any demand fill.
- rst asserted after 2 beats of a fill -> burst_read, pmem_resp, pf_valid go 0 asynchronously; a new request after reset performs a full 4-beat fill.

Source files
------------

// File: rtl/p_i_cache_line_fetch_if.sv
// Bus bundle for the I-cache line-fill engine: cache-side line request/response
// and memory-side 4-beat burst read.
interface p_i_cache_line_fetch_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  pmem_read;
   logic [ADDR_WIDTH-1:0] pmem_address;
   logic [255:0]          pmem_rdata;
   logic                  pmem_resp;
   logic                  burst_read;
   logic [ADDR_WIDTH-1:0] burst_address;
   logic [63:0]           burst_rdata;
   logic                  burst_resp;

   // slave: the fill engine itself
   modport slave (
      input  pmem_read, pmem_address, burst_rdata, burst_resp,
      output pmem_rdata, pmem_resp, burst_read, burst_address
   );

   // master: the I-cache and physical memory around it
   modport master (
      output pmem_read, pmem_address, burst_rdata, burst_resp,
      input  pmem_rdata, pmem_resp, burst_read, burst_address
   );
endinterface

// File: rtl/p_i_cache_line_fetch.sv
// I-cache line-fill engine: turns a single-line request into a 4-beat 64-bit
// burst and keeps a one-entry next-line prefetch buffer for sequential fetch.
module p_i_cache_line_fetch #(
   parameter bit PREFETCH_EN = 1'b1,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   p_i_cache_line_fetch_if.slave bus
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FILL_D  = 3'd1;
   localparam logic [2:0] S_RESP_D  = 3'd2;
   localparam logic [2:0] S_FILL_P  = 3'd3;
   localparam logic [2:0] S_RESP_PF = 3'd4;

   localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(32);

   logic [2:0]            r_state;
   logic [2:0]            w_state_nxt;
   logic [1:0]            r_beat_cnt;
   logic [ADDR_WIDTH-1:0] r_burst_address;
   logic [ADDR_WIDTH-1:0] r_pf_addr;
   logic                  r_pf_valid;
   logic                  r_pf_pending;
   logic [191:0]          r_line_buf;
   logic [255:0]          r_pf_buf;
   logic [255:0]          r_pmem_rdata;
   logic                  r_pmem_resp;

   logic [ADDR_WIDTH-1:0] w_req_line;
   logic                  w_addr_unused;
   logic                  w_filling;
   logic                  w_beat;
   logic                  w_last_beat;
   logic                  w_pf_hit;
   logic                  w_start_demand;
   logic                  w_start_prefetch;

   assign w_req_line    = {bus.pmem_address[ADDR_WIDTH-1:5], 5'b0};
   assign w_addr_unused = ^bus.pmem_address[4:0];

   // Beats outside a fill are dropped here, so stray burst_resp cannot corrupt state.
   assign w_filling   = (r_state == S_FILL_D) || (r_state == S_FILL_P);
   assign w_beat      = w_filling && bus.burst_resp;
   assign w_last_beat = w_beat && (r_beat_cnt == 2'd3);

   // pf_addr is always line aligned, so a full-width compare is a line compare.
   assign w_pf_hit         = bus.pmem_read && r_pf_valid && (w_req_line == r_pf_addr);
   assign w_start_demand   = (r_state == S_IDLE) && !w_pf_hit && bus.pmem_read;
   assign w_start_prefetch = (r_state == S_IDLE) && !bus.pmem_read && r_pf_pending;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_pf_hit)
               w_state_nxt = S_RESP_PF;
            else if (bus.pmem_read)
               w_state_nxt = S_FILL_D;
            else if (r_pf_pending)
               w_state_nxt = S_FILL_P;
         end
         S_FILL_D: begin
            if (w_last_beat)
               w_state_nxt = S_RESP_D;
         end
         S_FILL_P: begin
            if (w_last_beat)
               w_state_nxt = S_IDLE;
         end
         S_RESP_D:  w_state_nxt = S_IDLE;
         S_RESP_PF: w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_burst_address <= '0;
         r_beat_cnt      <= 2'd0;
      end else if (w_start_demand) begin
         r_burst_address <= w_req_line;
         r_beat_cnt      <= 2'd0;
      end else if (w_start_prefetch) begin
         r_burst_address <= r_pf_addr;
         r_beat_cnt      <= 2'd0;
      end else if (w_beat) begin
         r_beat_cnt      <= r_beat_cnt + 2'd1;
      end
   end

   // The 4th demand beat bypasses line_buf straight into pmem_rdata.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_line_buf <= '0;
         r_pf_buf   <= '0;
      end else if (w_beat) begin
         if (r_state == S_FILL_D) begin
            case (r_beat_cnt)
               2'd0:    r_line_buf[63:0]    <= bus.burst_rdata;
               2'd1:    r_line_buf[127:64]  <= bus.burst_rdata;
               2'd2:    r_line_buf[191:128] <= bus.burst_rdata;
               default: ;
            endcase
         end else begin
            r_pf_buf[{r_beat_cnt, 6'b0} +: 64] <= bus.burst_rdata;
         end
      end
   end

   // Response registers load on entry to RESP_D / RESP_PF so the pulse lines up with that state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pmem_resp  <= 1'b0;
         r_pmem_rdata <= '0;
      end else begin
         r_pmem_resp <= 1'b0;
         if ((r_state == S_FILL_D) && w_last_beat) begin
            r_pmem_resp  <= 1'b1;
            r_pmem_rdata <= {bus.burst_rdata, r_line_buf};
         end else if ((r_state == S_IDLE) && w_pf_hit) begin
            r_pmem_resp  <= 1'b1;
            r_pmem_rdata <= r_pf_buf;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pf_addr    <= '0;
         r_pf_valid   <= 1'b0;
         r_pf_pending <= 1'b0;
      end else begin
         case (r_state)
            S_RESP_D: begin
               r_pf_addr    <= r_burst_address + LINE_BYTES;
               r_pf_valid   <= 1'b0;
               r_pf_pending <= PREFETCH_EN;
            end
            S_RESP_PF: begin
               r_pf_addr    <= r_pf_addr + LINE_BYTES;
               r_pf_valid   <= 1'b0;
               r_pf_pending <= PREFETCH_EN;
            end
            S_FILL_P: begin
               if (w_last_beat) begin
                  r_pf_valid   <= 1'b1;
                  r_pf_pending <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.burst_read    = w_filling;
   assign bus.burst_address = r_burst_address;
   assign bus.pmem_resp     = r_pmem_resp;
   assign bus.pmem_rdata    = r_pmem_rdata;

endmodule

// File: tb/tb_p_i_cache_line_fetch.sv
// Bench for the I-cache line-fill engine: scoreboard of expected lines and
// expected burst addresses, with a randomly gapped burst memory model.
module tb_p_i_cache_line_fetch;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   p_i_cache_line_fetch_if #(.ADDR_WIDTH(32)) bus1 ();
   p_i_cache_line_fetch_if #(.ADDR_WIDTH(32)) bus2 ();

   p_i_cache_line_fetch #(.PREFETCH_EN(1'b1), .ADDR_WIDTH(32)) u_dut (
      .clk(clk), .rst(rst), .bus(bus1)
   );
   p_i_cache_line_fetch #(.PREFETCH_EN(1'b0), .ADDR_WIDTH(32)) u_dut_nopf (
      .clk(clk), .rst(rst), .bus(bus2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [255:0] data;
      int           gap;
   } sb_t;

   sb_t         sb_q[$];
   logic [31:0] burst_q[$];
   sb_t         mon_e;
   logic [31:0] rsp_addr;
   int          beat_limit = 4;
   int          cur_beats = 0;
   int          last4_cyc = 0;
   bit          stray_req = 1'b0;
   int          b2_k = 0;
   int          n_main;
   int          busy2;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] beat_data(input logic [31:0] a, input int k);
      logic [63:0] pat;
      pat = 64'h1111_1111_1111_1111 * 64'(k + 1);
      return pat ^ {a ^ 32'h0000_1000, 32'h0};
   endfunction

   function automatic logic [255:0] line_data(input logic [31:0] a);
      logic [31:0] la;
      la = {a[31:5], 5'b0};
      return {beat_data(la, 3), beat_data(la, 2), beat_data(la, 1), beat_data(la, 0)};
   endfunction

   function automatic logic [255:0] line2_data();
      logic [255:0] l;
      for (int k = 0; k < 4; k++)
         l[64*k +: 64] = 64'hB0B0_0000_0000_0000 | 64'(k);
      return l;
   endfunction

   // Response monitor for the prefetching instance
   always @(negedge clk) begin
      if (bus1.pmem_resp) begin
         if (sb_q.size() == 0) begin
            chk("resp_unexpected", 256'(1), 256'(0));
         end else begin
            mon_e = sb_q.pop_front();
            chk("rdata", bus1.pmem_rdata, mon_e.data);
            if (mon_e.gap > 0)
               chk("resp_gap", 256'(cyc - last4_cyc), 256'(mon_e.gap));
         end
      end
   end

   // Burst memory model for the prefetching instance
   initial begin
      bus1.burst_resp  = 1'b0;
      bus1.burst_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (bus1.burst_read && !rst) begin
            rsp_addr = bus1.burst_address;
            if (burst_q.size() == 0)
               chk("burst_unexpected", 256'(1), 256'(0));
            else
               chk("burst_addr", 256'(rsp_addr), 256'(burst_q.pop_front()));
            cur_beats = 0;
            for (int k = 0; k < 4; k++) begin
               if (k >= beat_limit) begin
                  while (bus1.burst_read) begin @(posedge clk); #1; end
                  break;
               end
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               if (!bus1.burst_read) break;
               chk("burst_addr_stable", 256'(bus1.burst_address), 256'(rsp_addr));
               bus1.burst_rdata = beat_data(rsp_addr, k);
               bus1.burst_resp  = 1'b1;
               cur_beats++;
               if (k == 3) last4_cyc = cyc;
               @(posedge clk); #1;
               bus1.burst_resp = 1'b0;
            end
         end else if (stray_req) begin
            stray_req        = 1'b0;
            bus1.burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            bus1.burst_resp  = 1'b1;
            @(posedge clk); #1;
            bus1.burst_resp = 1'b0;
         end
      end
   end

   // Back-to-back beat memory model for the non-prefetching instance
   initial begin
      bus2.burst_resp  = 1'b0;
      bus2.burst_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (bus2.burst_read) begin
            bus2.burst_rdata = 64'hB0B0_0000_0000_0000 | 64'(b2_k);
            bus2.burst_resp  = 1'b1;
            b2_k++;
         end else begin
            bus2.burst_resp = 1'b0;
            b2_k = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic do_req(input logic [31:0] a, input int gap, input int lat);
      int  n;
      sb_t e;
      n      = 0;
      e.data = line_data(a);
      e.gap  = gap;
      sb_q.push_back(e);
      bus1.pmem_read    = 1'b1;
      bus1.pmem_address = a;
      do begin @(posedge clk); #1; n++; end while (!bus1.pmem_resp && n < 300);
      if (!bus1.pmem_resp)
         chk("req_timeout", 256'(1), 256'(0));
      else if (lat > 0)
         chk("req_latency", 256'(n), 256'(lat));
      @(posedge clk); #1;
      bus1.pmem_read = 1'b0;
   endtask

   task automatic wait_quiet();
      int n;
      n = 0;
      while ((burst_q.size() != 0 || bus1.burst_read) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 500) chk("quiet_timeout", 256'(1), 256'(0));
   endtask

   task automatic req2(input logic [31:0] a);
      int n;
      n = 0;
      bus2.pmem_read    = 1'b1;
      bus2.pmem_address = a;
      do begin @(posedge clk); #1; n++; end while (!bus2.pmem_resp && n < 100);
      chk("nopf_latency", 256'(n), 256'(5));
      chk("nopf_rdata", bus2.pmem_rdata, line2_data());
      @(posedge clk); #1;
      bus2.pmem_read = 1'b0;
   endtask

   initial begin
      bus1.pmem_read    = 1'b0;
      bus1.pmem_address = '0;
      bus2.pmem_read    = 1'b0;
      bus2.pmem_address = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pmem_resp", 256'(bus1.pmem_resp), 256'(0));
      chk("rst_pmem_rdata", bus1.pmem_rdata, 256'(0));
      chk("rst_burst_read", 256'(bus1.burst_read), 256'(0));
      chk("rst_burst_addr", 256'(bus1.burst_address), 256'(0));
      chk("rst_nopf_burst_read", 256'(bus2.burst_read), 256'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Demand miss, then the next line is prefetched
      burst_q.push_back(32'h0000_1000);
      burst_q.push_back(32'h0000_1020);
      do_req(32'h0000_1004, 1, 0);

      // Demand for the line being prefetched waits for the prefetch to finish
      n_main = 0;
      while (!bus1.burst_read && n_main < 50) begin @(posedge clk); #1; n_main++; end
      chk("pf_launch", 256'(bus1.burst_read), 256'(1));
      burst_q.push_back(32'h0000_1040);
      do_req(32'h0000_1030, 2, 0);
      wait_quiet();

      // Prefetch hit served in one cycle without a burst
      burst_q.push_back(32'h0000_1060);
      do_req(32'h0000_1044, 0, 1);
      wait_quiet();

      // Miss to an unrelated line discards the buffer and retargets prefetch
      burst_q.push_back(32'h0000_2000);
      burst_q.push_back(32'h0000_2020);
      do_req(32'h0000_2008, 1, 0);
      wait_quiet();

      // A beat outside any fill must be ignored
      stray_req = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      burst_q.push_back(32'h0000_2040);
      do_req(32'h0000_2020, 0, 1);
      wait_quiet();

      // Prefetch address wraps at the top of the address space
      burst_q.push_back(32'hFFFF_FFE0);
      burst_q.push_back(32'h0000_0000);
      do_req(32'hFFFF_FFE4, 1, 0);
      wait_quiet();
      burst_q.push_back(32'h0000_0020);
      do_req(32'h0000_0010, 0, 1);
      wait_quiet();

      // Asynchronous reset after two beats of a demand fill
      beat_limit = 2;
      burst_q.push_back(32'h0000_5000);
      bus1.pmem_read    = 1'b1;
      bus1.pmem_address = 32'h0000_5008;
      n_main = 0;
      while (!(bus1.burst_read && burst_q.size() == 0 && cur_beats == 2) && n_main < 100) begin
         @(posedge clk); #1;
         n_main++;
      end
      chk("rst_mid_fill_reached", 256'(cur_beats), 256'(2));
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_burst_read", 256'(bus1.burst_read), 256'(0));
      chk("arst_pmem_resp", 256'(bus1.pmem_resp), 256'(0));
      chk("arst_burst_addr", 256'(bus1.burst_address), 256'(0));
      chk("arst_pmem_rdata", bus1.pmem_rdata, 256'(0));
      bus1.pmem_read = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst        = 1'b0;
      beat_limit = 4;
      repeat (3) @(posedge clk);
      #1;

      // Buffer held line 0x20 before reset; it must now be a full fill
      burst_q.push_back(32'h0000_0020);
      burst_q.push_back(32'h0000_0040);
      do_req(32'h0000_0024, 1, 0);
      wait_quiet();

      // Demand-only instance: fills work, no burst ever follows a fill
      req2(32'h0000_3004);
      busy2 = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus2.burst_read) busy2++;
      end
      chk("nopf_no_prefetch", 256'(busy2), 256'(0));
      req2(32'h0000_3020);

      repeat (5) @(posedge clk);
      #1;
      chk("sb_drained", 256'(sb_q.size()), 256'(0));
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
